up_counter_tff: RTL and testbench
=================================

Name: up_counter_tff

Overview:
- Loadable synchronous up counter built from per-bit T flip-flops; the count-up counterpart to the team's loadable TFF down counter.
- Counts from a loaded start value toward a programmable limit.
- Either wraps to zero with a one-cycle wrap pulse, or saturates at the limit.
- Sits in the tile top level, which drives it directly from the dedicated and bidirectional input pins.

Parameters:
- bits, 9, counter width; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- load_en  input  1  load data into the counter on this edge; has priority over counting
- en  input  1  count enable
- saturate  input  1  1 = hold at the terminal value; 0 = wrap to zero
- data  input  bits  load value
- limit  input  bits  terminal count value
- out  output  bits  current count (registered)
- tc  output  1  terminal count flag, combinational: (out == limit) OR (out == all-ones)
- wrap_pulse  output  1  registered one-cycle pulse following a wrap

Behaviour:
- Reset (rst_n low at the rising edge): out = 0 and wrap_pulse = 0. Reset overrides load_en and en.
- Reset mid-count takes effect on that edge; counting resumes from 0 on the first edge with rst_n high.
- Register structure:
  - Each bit of out is a T flip-flop with toggle input t[i].
  - t[i] = en AND (out[i-1:0] all ones); t[0] = en.
  - Load and wrap are applied as a synchronous override of the T-FF next state.
  - A single behavioural adder is not acceptable; out+1 must be formed by the toggle chain.
- Per-edge priority, highest first:
  1. Reset.
  2. load_en = 1: out <= data; wrap_pulse <= 0. This holds whatever en is, and even if out == limit.
  3. en = 1 and tc = 1 and saturate = 1: out holds; wrap_pulse <= 0.
  4. en = 1 and tc = 1 and saturate = 0: out <= 0; wrap_pulse <= 1.
  5. en = 1 and tc = 0: out <= out + 1 via the toggle chain; wrap_pulse <= 0.
  6. en = 0: out holds; wrap_pulse <= 0.
- Latency:
  - out reflects a load or increment one cycle after the qualifying edge.
  - tc follows out combinationally, so it updates in the same cycle as out.
  - wrap_pulse is high for exactly the one cycle in which out first reads 0 after a wrap.
- Terminal value:
  - tc includes all-ones, so a load with data > limit counts up to all-ones and then wraps (or saturates there) instead of overflowing silently.
  - limit = 0 with saturate = 0: out stays 0 and wrap_pulse stays high for every enabled cycle.
  - limit = 0 with saturate = 1: out holds at 0.
- limit is sampled live:
  - Changing limit mid-count takes effect on the next edge.
  - If the new limit is below the current out, counting continues to all-ones.
- saturate is sampled live. Clearing saturate while holding at the terminal value wraps on the next enabled edge.
- Widths: all arithmetic is modulo 2^bits. No output other than out, tc and wrap_pulse carries state.

Test Plan (bits = 9):
1. Reset then count: rst_n low 2 cycles, then high; en = 1, limit = 511, saturate = 0 for 520 cycles.
   - During reset: out = 0, wrap_pulse = 0.
   - out = 0, 1, 2, ... 511, then 0 with wrap_pulse = 1 for one cycle, then 1.
   - tc = 1 only while out = 511.
2. Load and limit wrap: load_en = 1 with data = 0x0FA, then en = 1, limit = 0x100, saturate = 0.
   - out = 0x0FA, then counts to 0x100 (tc = 1), then 0x000 with wrap_pulse = 1, then 0x001.
3. Saturate: data = 0x1FD, limit = 0x1FF, saturate = 1, en = 1 for 10 cycles.
   - out = 0x1FE, 0x1FF, then holds 0x1FF; tc = 1; wrap_pulse stays 0.
   - Then set saturate = 0: next edge gives out = 0 and wrap_pulse = 1.
4. Load and enable priority: out = 0x055, en = 1, load_en = 1, data = 0x0AA in the same cycle → out = 0x0AA, not 0x056.
   - Then en = 0 for 5 cycles → out holds 0x0AA.
5. Load above limit: data = 0x1F0, limit = 0x010, saturate = 0, en = 1.
   - Counts 0x1F0 to 0x1FF (tc = 1 at 0x1FF), then 0x000 with wrap_pulse = 1, then continues to 0x010, then wraps again.
6. Reset mid-count: out = 0x123 with en = 1; assert rst_n low for 1 cycle → out = 0 on that edge; wrap_pulse = 0.
   - Release → out = 1 on the next edge.
   - Bench also compares against a reference model of out + 1 every cycle across a random mix of en, load_en and limit.

Source files
------------

// File: rtl/up_counter_tff.sv
// Loadable synchronous up counter built from per-bit T flip-flops. It counts
// toward a programmable limit, then either wraps to zero with a one-cycle pulse
// or saturates at the limit.
module up_counter_tff #(
  parameter int bits = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            en,
  input  logic            saturate,
  input  logic [bits-1:0] data,
  input  logic [bits-1:0] limit,
  output logic [bits-1:0] out,
  output logic            tc,
  output logic            wrap_pulse
);

  logic [bits-1:0] r_count;
  logic            r_wrap;
  logic [bits-1:0] w_t;
  logic [bits-1:0] w_tff_next;
  logic [bits-1:0] w_next;
  logic            w_wrap_next;
  logic            w_tc;

  // Bit i toggles only when every lower bit is already one.
  assign w_t[0] = en;
  for (genvar g = 1; g < bits; g++) begin : g_toggle
    assign w_t[g] = en & (&r_count[g-1:0]);
  end

  assign w_tff_next = r_count ^ w_t;

  // All-ones also terminates the count, so a load above the limit cannot roll over silently.
  assign w_tc = (r_count == limit) | (&r_count);

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_next      = w_tff_next;
    w_wrap_next = 1'b0;
    if (load_en) begin
      w_next = data;
    end else if (en && w_tc) begin
      if (saturate) begin
        w_next = r_count;
      end else begin
        w_next      = '0;
        w_wrap_next = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous and has top priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_wrap_next;
    end
  end

  assign out        = r_count;
  assign tc         = w_tc;
  assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_up_counter_tff.sv
// Self-checking bench for up_counter_tff: directed scenarios pinned with literal
// values, plus a randomized phase checked every cycle against an arithmetic model.
module tb_up_counter_tff;

  localparam int          BITS = 9;
  localparam int unsigned MAXV = (1 << BITS) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_en;
  logic            en;
  logic            saturate;
  logic [BITS-1:0] data;
  logic [BITS-1:0] limit;
  logic [BITS-1:0] out;
  logic            tc;
  logic            wrap_pulse;

  int n_pass  = 0;
  int n_total = 0;

  int unsigned m_out  = 0;
  bit          m_wrap = 1'b0;

  up_counter_tff #(.bits(BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .en         (en),
    .saturate   (saturate),
    .data       (data),
    .limit      (limit),
    .out        (out),
    .tc         (tc),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: plain arithmetic on the counting rules, updated on each
  // rising edge from the inputs that edge sees, then compared 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_out  = 0;
      m_wrap = 1'b0;
    end else if (load_en) begin
      m_out  = int'(data);
      m_wrap = 1'b0;
    end else if (en && (m_out == int'(limit) || m_out == MAXV)) begin
      if (saturate) begin
        m_wrap = 1'b0;
      end else begin
        m_out  = 0;
        m_wrap = 1'b1;
      end
    end else if (en) begin
      m_out  = (m_out + 1) % (MAXV + 1);
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
    end
    #1;
    check("model_out",  32'(out),        32'(m_out));
    check("model_tc",   32'(tc),         32'((m_out == int'(limit)) || (m_out == MAXV)));
    check("model_wrap", 32'(wrap_pulse), 32'(m_wrap));
  end

  // Advance n edges; returns 2 time units after the last edge with inputs still stable.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [BITS-1:0] value);
    load_en = 1'b1;
    data    = value;
    tick(1);
    load_en = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    load_en  = 1'b0;
    en       = 1'b0;
    saturate = 1'b0;
    data     = '0;
    limit    = 9'h1FF;

    // 1. Reset then free count over the full range.
    tick(2);
    check("reset_out",  32'(out),        32'h0);
    check("reset_wrap", 32'(wrap_pulse), 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 1; i <= 511; i++) begin
      tick(1);
      check("count_out", 32'(out), 32'(i));
      check("count_tc",  32'(tc),  32'(i == 511));
    end
    tick(1);
    check("full_wrap_out",   32'(out),        32'h0);
    check("full_wrap_pulse", 32'(wrap_pulse), 32'h1);
    tick(1);
    check("after_wrap_out",   32'(out),        32'h1);
    check("after_wrap_pulse", 32'(wrap_pulse), 32'h0);

    // 2. Load then wrap at a programmed limit.
    limit = 9'h100;
    load(9'h0FA);
    check("load_0fa", 32'(out), 32'h0FA);
    tick(6);
    check("limit_reached", 32'(out), 32'h100);
    check("limit_tc",      32'(tc),  32'h1);
    tick(1);
    check("limit_wrap_out",   32'(out),        32'h0);
    check("limit_wrap_pulse", 32'(wrap_pulse), 32'h1);
    tick(1);
    check("limit_after_out", 32'(out), 32'h1);

    // 3. Saturate at the limit, then release saturation.
    limit    = 9'h1FF;
    saturate = 1'b1;
    load(9'h1FD);
    tick(1);
    check("sat_1fe", 32'(out), 32'h1FE);
    tick(1);
    check("sat_1ff", 32'(out), 32'h1FF);
    tick(8);
    check("sat_hold_out",  32'(out),        32'h1FF);
    check("sat_hold_tc",   32'(tc),         32'h1);
    check("sat_hold_wrap", 32'(wrap_pulse), 32'h0);
    saturate = 1'b0;
    tick(1);
    check("unsat_wrap_out",   32'(out),        32'h0);
    check("unsat_wrap_pulse", 32'(wrap_pulse), 32'h1);

    // 4. Load has priority over enable; en low holds.
    load(9'h055);
    load(9'h0AA);
    check("load_priority", 32'(out), 32'h0AA);
    en = 1'b0;
    tick(5);
    check("hold_disabled", 32'(out), 32'h0AA);

    // 5. Load above the limit counts to all-ones, wraps, then honours the limit.
    en    = 1'b1;
    limit = 9'h010;
    load(9'h1F0);
    tick(15);
    check("above_1ff",    32'(out), 32'h1FF);
    check("above_1ff_tc", 32'(tc),  32'h1);
    tick(1);
    check("above_wrap_out",   32'(out),        32'h0);
    check("above_wrap_pulse", 32'(wrap_pulse), 32'h1);
    tick(16);
    check("above_limit_out", 32'(out), 32'h010);
    tick(1);
    check("above_wrap2_pulse", 32'(wrap_pulse), 32'h1);

    // Limit of zero: wraps every enabled edge, or holds when saturating.
    limit = 9'h000;
    tick(3);
    check("lim0_out",   32'(out),        32'h0);
    check("lim0_pulse", 32'(wrap_pulse), 32'h1);
    saturate = 1'b1;
    tick(2);
    check("lim0_sat_out",   32'(out),        32'h0);
    check("lim0_sat_pulse", 32'(wrap_pulse), 32'h0);
    saturate = 1'b0;

    // 6. Reset mid-count.
    limit = 9'h1FF;
    load(9'h123);
    rst_n = 1'b0;
    tick(1);
    check("midrst_out",  32'(out),        32'h0);
    check("midrst_wrap", 32'(wrap_pulse), 32'h0);
    rst_n = 1'b1;
    tick(1);
    check("midrst_resume", 32'(out), 32'h1);

    // Randomized mix, checked every cycle by the model process.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      load_en  = ($urandom_range(0, 15) == 0);
      saturate = ($urandom_range(0, 3) == 0);
      data     = BITS'($urandom);
      rst_n    = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 31) == 0) limit = BITS'($urandom);
      else if ($urandom_range(0, 63) == 0) limit = '0;
      tick(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
